regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Parametrised integer register file for the multi-cycle pipelined RISC-V core. It provides NREAD combinational read ports, one write-back port, and optional write-to-read bypass. Register 0 is hardwired to zero. An integrated per-register busy scoreboard tracks in-flight destinations and generates the issue stall for the decode stage.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of read ports
BYPASS, 1, 1 = write-back data forwarded to same-cycle reads; 0 = reads see stored value only
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
rd_addr  in  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW]
rd_used  in  NREAD  port i operand is actually needed by the issuing instruction
rd_data  out  NREAD*XLEN  packed read data; port i = bits [i*XLEN +: XLEN]
wr_en  in  1  write-back valid
wr_addr  in  AW  write-back destination
wr_data  in  XLEN  write-back data
issue_valid  in  1  decode presents an instruction for issue
issue_rd  in  AW  destination of the issuing instruction (0 = no destination)
stall  out  1  issue blocked this cycle
issue_fire  out  1  issue_valid && !stall
busy_vec  out  NREGS  scoreboard bits, bit 0 always 0
busy_count  out  $clog2(NREGS+1)  number of set busy bits
wb_err  out  1  sticky: write-back to a non-busy register seen

Behaviour:
- Reset: rst_n is synchronous and active-low, sampled only at the rising clk edge. While low at an edge, all NREGS storage entries are cleared to 0, busy_vec is cleared, and wb_err is cleared. All other inputs are ignored during that cycle.
- Because outputs are combinational from state, after the reset edge rd_data=0, stall=0 and busy_count=0.
- A reset asserted mid-operation discards all pending busy bits. A write-back arriving in the reset cycle is dropped.
- Reads are combinational with zero latency. rd_data[i] = 0 if rd_addr[i]==0.
  - Otherwise, if BYPASS && wr_en && wr_addr==rd_addr[i], rd_data[i] = wr_data.
  - Otherwise rd_data[i] = storage[rd_addr[i]].
- Write: at the edge, if wr_en && wr_addr!=0, storage[wr_addr] <= wr_data. Writes to address 0 are discarded.
- Scoreboard clear: wr_en && wr_addr!=0 clears busy[wr_addr] at the edge.
  - If busy[wr_addr] was already 0, wb_err is set (sticky) and the data is still written.
- Read hazard, per port i: rd_used[i] && rd_addr[i]!=0 && busy[rd_addr[i]].
  - The hazard is suppressed when BYPASS=1 and the same register is being written back this cycle (wr_en && wr_addr==rd_addr[i]).
  - When BYPASS=0 the hazard is not suppressed; stall persists until the cycle after write-back.
- WAW hazard: issue_valid && issue_rd!=0 && busy[issue_rd] && !(wr_en && wr_addr==issue_rd).
- stall = issue_valid && (any read hazard || WAW hazard). stall is 0 whenever issue_valid=0.
- Issue: on issue_fire with issue_rd!=0, busy[issue_rd] is set at the edge.
- Simultaneous set and clear of the same register in one cycle: the set wins, so the new instruction owns the register. This is not a wb_err if the bit was busy.
- busy_count is combinational popcount of busy_vec and ranges 0..NREGS-1.
- There are no multi-cycle paths and no internal FSM beyond the scoreboard and the sticky error bit.

Decomposition:
- Shared package rv_core_pkg holds XLEN and NREGS defaults, the REG_ZERO constant, and a typedef for the register address.
- One natural sub-module is reg_scoreboard: busy bits, hazard and stall logic, wb_err, and popcount. Storage and read muxing stay in the top module.

Test Plan:
- Reset then read: hold rst_n=0 for one edge, then read x5 and x31 -> rd_data=0, stall=0, busy_count=0, wb_err=0.
- Write then read: write x3=0xDEADBEEF, next cycle read port0=x3 -> 0xDEADBEEF. Write x0=0x1234 -> reading x0 returns 0.
- Bypass: with BYPASS=1, write x7=0xA5A5A5A5 and read x7 on port1 in the same cycle -> 0xA5A5A5A5. With BYPASS=0, the same stimulus returns the old x7 value.
- RAW stall: issue rd=x4 (fires), then issue with rs1=x4 and rd_used=01 -> stall=1 until the x4 write-back cycle. With BYPASS=1, stall drops in the write-back cycle; with BYPASS=0, it drops the cycle after.
- WAW plus same-cycle set/clear: issue rd=x9, then in one cycle write back x9 and issue rd=x9 again -> issue_fire=1, busy[9] stays 1, wb_err=0, busy_count=1.
- Error and reset mid-operation: write back x12 while busy[12]=0 -> wb_err=1 and stays 1. Issue rd=x2, then assert rst_n=0 -> busy_vec=0 and wb_err=0 next cycle.

Source files
------------

// File: rtl/rv_core_pkg.sv
// rtl/rv_core_pkg.sv - shared integer-core constants and register address type
package rv_core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Architectural index of the hardwired-zero register
    localparam int REG_ZERO  = 0;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy tracking, issue hazard detection and wb_err
module reg_scoreboard
    import rv_core_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS),
    parameter int CW     = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREAD*AW-1:0] rd_addr,
    input  logic [NREAD-1:0]    rd_used,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                stall,
    output logic                issue_fire,
    output logic [NREGS-1:0]    busy_vec,
    output logic [CW-1:0]       busy_count,
    output logic                wb_err
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam bit            BYP       = (BYPASS != 0);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [NREAD-1:0] rd_hazard;
    logic             waw_hazard;
    logic             wb_valid;
    logic             wb_err_set;

    // A write-back to x0 carries no architectural effect and never touches the scoreboard
    assign wb_valid = wr_en && (wr_addr != ZERO_ADDR);

    // Per-port RAW hazard; a same-cycle write-back only hides it when the bypass can deliver the data
    always_comb begin
        rd_hazard = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_hazard[i] = rd_used[i]
                        && (rd_addr[i*AW +: AW] != ZERO_ADDR)
                        && busy[rd_addr[i*AW +: AW]]
                        && !(BYP && wr_en && (wr_addr == rd_addr[i*AW +: AW]));
        end
    end

    // WAW hazard is relieved by the matching write-back regardless of bypass, since the new owner takes over
    always_comb begin
        waw_hazard = issue_valid
                  && (issue_rd != ZERO_ADDR)
                  && busy[issue_rd]
                  && !(wr_en && (wr_addr == issue_rd));
        stall      = issue_valid && ((|rd_hazard) || waw_hazard);
        issue_fire = issue_valid && !stall;
    end

    // Next busy state: write-back clears first, then issue sets, so a same-cycle re-issue keeps the bit
    always_comb begin
        busy_next  = busy;
        wb_err_set = 1'b0;
        if (wb_valid) begin
            wb_err_set         = !busy[wr_addr];
            busy_next[wr_addr] = 1'b0;
        end
        if (issue_fire && (issue_rd != ZERO_ADDR)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    // Scoreboard and sticky error register; reset drops every in-flight destination
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            busy <= busy_next;
            if (wb_err_set) begin
                wb_err <= 1'b1;
            end
        end
    end

    // Population count of outstanding destinations
    always_comb begin
        busy_count = '0;
        for (int i = 0; i < NREGS; i++) begin
            busy_count = busy_count + CW'(busy[i]);
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with bypassed read ports and issue scoreboard
module regfile_scoreboard
    import rv_core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS),
    parameter int CW     = $clog2(NREGS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    input  logic [NREAD-1:0]      rd_used,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  stall,
    output logic                  issue_fire,
    output logic [NREGS-1:0]      busy_vec,
    output logic [CW-1:0]         busy_count,
    output logic                  wb_err
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam bit            BYP       = (BYPASS != 0);

    logic [XLEN-1:0] storage [NREGS];

    // Register storage; x0 is never written so it stays zero after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                storage[r] <= '0;
            end
        end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
            storage[wr_addr] <= wr_data;
        end
    end

    // Zero-latency read ports with optional forwarding of the in-flight write-back
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_addr[i*AW +: AW] == ZERO_ADDR) begin
                rd_data[i*XLEN +: XLEN] = '0;
            end else if (BYP && wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
                rd_data[i*XLEN +: XLEN] = wr_data;
            end else begin
                rd_data[i*XLEN +: XLEN] = storage[rd_addr[i*AW +: AW]];
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NREAD  (NREAD),
        .BYPASS (BYPASS),
        .AW     (AW),
        .CW     (CW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_used     (rd_used),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .issue_fire  (issue_fire),
        .busy_vec    (busy_vec),
        .busy_count  (busy_count),
        .wb_err      (wb_err)
    );

endmodule
